uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning i_Clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter DEPTH, default 16, meaning FIFO words, power of two, minimum 2.
REQ-006 SHALL have port i_Clk, input, 1, meaning system clock.
REQ-007 SHALL have port w_rst, input, 1, meaning reset, synchronous, active-high.
REQ-008 SHALL have port i_rx_in, input, 1, meaning asynchronous serial line, idle high.
REQ-009 SHALL have port o_rx_data, output, DATA_BITS, meaning FIFO head word.
REQ-010 SHALL have port o_rx_valid, output, 1, meaning FIFO non-empty.
REQ-011 SHALL have port i_rx_ready, input, 1, meaning consumer pop request.
REQ-012 SHALL have port o_fifo_count, output, clog2(DEPTH)+1, meaning words held.
REQ-013 SHALL have port o_parity_err, output, 1, meaning sticky parity error.
REQ-014 SHALL have port o_frame_err, output, 1, meaning sticky framing error.
REQ-015 SHALL have port o_overflow, output, 1, meaning sticky FIFO overflow.
REQ-016 SHALL have port i_clr_err, input, 1, meaning clear all sticky flags.

Function
REQ-017 SHALL pass i_rx_in through a 2-flop synchroniser; all decoding uses the synchronised value.
REQ-018 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division); SHALL sample at bit centre, CLKS_PER_BIT/2 after start edge, then every CLKS_PER_BIT.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-020 IDLE->START on synchronised line low.
REQ-021 START: line high at mid-start -> IDLE (glitch reject, nothing pushed); low -> DATA.
REQ-022 DATA: shift DATA_BITS samples LSB first; -> PARITY if PARITY!=0, else -> STOP.
REQ-023 PARITY: odd mode requires data+parity bit to have odd count of ones; even mode, even; mismatch marks frame bad-parity.
REQ-024 STOP: at mid-stop, stop=1 and parity good -> push word, -> IDLE; stop=1 and parity bad -> set o_parity_err, no push, -> IDLE; stop=0 -> set o_frame_err, no push, -> BREAK.
REQ-025 BREAK: remain until line high, then -> IDLE.
REQ-026 Pushed word SHALL appear on o_rx_data with o_rx_valid=1 one cycle after the mid-stop sample cycle when FIFO was empty (first-word fall-through).
REQ-027 Pop SHALL occur on cycles where o_rx_valid && i_rx_ready; next word presented the following cycle.
REQ-028 Push when full and no pop in same cycle: new word dropped, FIFO unchanged, o_overflow set.
REQ-029 Push and pop in same cycle when full: both accepted, count unchanged, no overflow.
REQ-030 Push and pop in same cycle when count 1..DEPTH-1: count unchanged, order preserved.
REQ-031 i_rx_ready with FIFO empty SHALL have no effect.
REQ-032 i_clr_err SHALL clear sticky flags next cycle; a set event in the same cycle wins.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 On w_rst: FSM IDLE, counters 0, synchroniser flops 1, FIFO empty, o_rx_valid 0, o_fifo_count 0, o_rx_data 0, all sticky flags 0.
REQ-035 Reset mid-frame SHALL abandon the frame with no push and no flag; after release, the receiver waits for the line in IDLE and a subsequent line-low is treated as a new start bit.

Structure
REQ-036 Package uart_pkg SHALL hold parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and FSM state encoding.
REQ-037 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification (CLK_FREQ 25 MHz, BAUD 115200, CLKS_PER_BIT 217)
REQ-038 8N1, send 0x31 -> o_rx_data 0x31, o_rx_valid 1 within 1 cycle of mid-stop, no flags.
REQ-039 PARITY=2, send 0xA5 with parity bit 1 -> no push, o_parity_err 1; resend with parity 0 -> 0xA5 pushed.
REQ-040 Stop bit 0 then line held low 3 bit-times -> o_frame_err 1, no push, FSM returns IDLE only after line high; next 0x55 received correctly.
REQ-041 DEPTH=4, i_rx_ready 0, send 0x01..0x05 -> count 4, o_overflow 1, pops yield 0x01..0x04.
REQ-042 Low pulse of 50 cycles on idle line -> no push, no flags.
REQ-043 w_rst asserted mid-DATA of 0x7E -> all outputs at reset values, no word pushed; following 0x42 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and parity helper for the UART
// receive path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // ones_odd is the XOR of data and parity bit; returns 1 when the frame fails.
  function automatic logic parity_bad(input logic ones_odd, input int mode);
    if (mode == PAR_ODD)  return !ones_odd;
    if (mode == PAR_EVEN) return ones_odd;
    return 1'b0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO: the array read is registered into a head
// register that always holds the word that is current on the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_Clk,
  input  logic                     w_rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty, full, do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign do_pop     = pop_i && !empty;
  assign do_push    = push_i && (!full || do_pop);
  assign overflow_o = push_i && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // The slot becoming head may be the one written this very cycle.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = !empty;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, sticky error flags
// and a first-word fall-through receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int DEPTH     = 16
) (
  input  logic                   i_Clk,
  input  logic                   w_rst,
  input  logic                   i_rx_in,
  output logic [DATA_BITS-1:0]   o_rx_data,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ready,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_parity_err,
  output logic                   o_frame_err,
  output logic                   o_overflow,
  input  logic                   i_clr_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BW = ($clog2(DATA_BITS) < 1) ? 1 : $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic                 push, set_par, set_frame, fifo_ovf;

  always_ff @(posedge i_Clk) begin
    if (w_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frame = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        par_bad_d = 1'b0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_bad_d = parity_bad(^shift_q ^ rx_s, PARITY);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (!rx_s) begin
            set_frame = 1'b1;
            state_d   = ST_BREAK;
          end else if (par_bad_q) begin
            set_par = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Hold off start detection until the line returns to idle.
        clk_cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // A set event in the same cycle as a clear takes priority.
  always_comb begin
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overflow_d   = overflow_q;
    if (i_clr_err) begin
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overflow_d   = 1'b0;
    end
    if (set_par)   parity_err_d = 1'b1;
    if (set_frame) frame_err_d  = 1'b1;
    if (fifo_ovf)  overflow_d   = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (w_rst) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .w_rst      (w_rst),
    .push_i     (push),
    .data_i     (shift_q),
    .pop_i      (i_rx_ready),
    .data_o     (o_rx_data),
    .valid_o    (o_rx_valid),
    .count_o    (o_fifo_count),
    .overflow_o (fifo_ovf)
  );

  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_overflow   = overflow_q;

endmodule
